gate_response_checker: RTL and testbench

- Synthesizable self-checking monitor for the basic-gate block. It sits on the output side of the gate block, opposite the stimulus driver.
- Samples the two gate inputs and the six gate outputs on each valid cycle. Compares the outputs against a built-in reference model, counts mismatches and tracks input-combination coverage.
- Reports done/pass once all four input combinations have been seen, or reports a timeout.

---
 rtl/gate_check_pkg.sv | 51 +++++
 rtl/gate_ref_model.sv | 21 ++
 rtl/gate_response_checker.sv | 157 +++++++++++++++
 tb/tb_gate_response_checker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// Shared definitions for the basic-gate response checker: FSM encoding,
// mask bit positions and small helpers used by the checker and reference model.
package gate_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit positions inside the 6-bit expected/actual/mismatch vectors.
    localparam int IDX_NOT  = 5;
    localparam int IDX_AND  = 4;
    localparam int IDX_OR   = 3;
    localparam int IDX_XOR  = 2;
    localparam int IDX_NOR  = 1;
    localparam int IDX_NAND = 0;

    localparam int MASK_W          = 6;
    localparam int COV_W           = 4;
    localparam int TMR_W           = 16;
    localparam int DEFAULT_TIMEOUT = 64;

    // Gather the six gate outputs into mask bit order.
    function automatic logic [MASK_W-1:0] pack_outputs(
        input logic y_not,
        input logic y_and,
        input logic y_or,
        input logic y_xor,
        input logic y_nor,
        input logic y_nand
    );
        logic [MASK_W-1:0] v;
        v           = '0;
        v[IDX_NOT]  = y_not;
        v[IDX_AND]  = y_and;
        v[IDX_OR]   = y_or;
        v[IDX_XOR]  = y_xor;
        v[IDX_NOR]  = y_nor;
        v[IDX_NAND] = y_nand;
        return v;
    endfunction

    // One-hot coverage bit for input combination {a,b}.
    function automatic logic [COV_W-1:0] combo_onehot(input logic a, input logic b);
        logic [COV_W-1:0] one;
        one = {{(COV_W-1){1'b0}}, 1'b1};
        return one << {a, b};
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the basic-gate block; produces the expected
// outputs for inputs a and b in mask bit order {not,and,or,xor,nor,nand}.
module gate_ref_model
    import gate_check_pkg::*;
(
    input  logic              a,
    input  logic              b,
    output logic [MASK_W-1:0] expected
);

    always_comb begin
        expected           = '0;
        expected[IDX_NOT]  = ~a;
        expected[IDX_AND]  = a & b;
        expected[IDX_OR]   = a | b;
        expected[IDX_XOR]  = a ^ b;
        expected[IDX_NOR]  = ~(a | b);
        expected[IDX_NAND] = ~(a & b);
    end

endmodule

// File: rtl/gate_response_checker.sv
// Self-checking monitor for the basic-gate block: compares sampled outputs with
// the reference model, counts samples/mismatches and tracks input coverage.
module gate_response_checker
    import gate_check_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    // sample_valid is a one-sided qualifier with no back-pressure: every cycle
    // it is high in RUN, the same-cycle a/b/y_* values are consumed as one vector.
    input  logic              sample_valid,
    input  logic              a,
    input  logic              b,
    input  logic              y_not,
    input  logic              y_and,
    input  logic              y_or,
    input  logic              y_xor,
    input  logic              y_nor,
    input  logic              y_nand,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  sample_count,
    output logic [COV_W-1:0]  coverage,
    output logic [1:0]        first_fail_vec,
    output logic [MASK_W-1:0] first_fail_mask,
    output logic              first_fail_valid,
    output logic [1:0]        state_dbg
);

    localparam logic [TMR_W-1:0] LAST_CYCLE = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   cyc_q;
    logic [CNT_W-1:0]   err_q, smp_q;
    logic [COV_W-1:0]   cov_q;
    logic [1:0]         ffv_q;
    logic [MASK_W-1:0]  ffm_q;
    logic               ffval_q;
    logic               timeout_q;

    logic [MASK_W-1:0]  expected;
    logic [MASK_W-1:0]  actual;
    logic [MASK_W-1:0]  mask;
    logic               in_run;
    logic               accept;
    logic               launch;
    logic               mismatch;
    logic [COV_W-1:0]   cov_next;
    logic               cov_full;
    logic               time_up;

    gate_ref_model u_ref (
        .a        (a),
        .b        (b),
        .expected (expected)
    );

    always_comb begin
        actual   = pack_outputs(y_not, y_and, y_or, y_xor, y_nor, y_nand);
        mask     = actual ^ expected;
        in_run   = (state_q == ST_RUN);
        accept   = in_run && sample_valid;
        launch   = start && (state_q == ST_IDLE || state_q == ST_DONE);
        mismatch = accept && (mask != '0);
        cov_next = cov_q;
        if (accept) begin
            cov_next = cov_q | combo_onehot(a, b);
        end
        cov_full = (cov_next == 4'hF);
        time_up  = (cyc_q == LAST_CYCLE);
    end

    // Coverage completion is tested first so it wins over a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cov_full) begin
                    state_d = ST_DONE;
                end else if (time_up) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || launch) begin
            cyc_q     <= '0;
            err_q     <= '0;
            smp_q     <= '0;
            cov_q     <= '0;
            ffv_q     <= '0;
            ffm_q     <= '0;
            ffval_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else if (in_run) begin
            cyc_q <= cyc_q + TMR_W'(1);
            cov_q <= cov_next;
            if (accept && smp_q != CNT_MAX) begin
                smp_q <= smp_q + CNT_W'(1);
            end
            if (mismatch && err_q != CNT_MAX) begin
                err_q <= err_q + CNT_W'(1);
            end
            if (mismatch && !ffval_q) begin
                ffv_q   <= {a, b};
                ffm_q   <= mask;
                ffval_q <= 1'b1;
            end
            if (time_up && !cov_full) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        busy             = (state_q == ST_RUN);
        done             = (state_q == ST_DONE);
        pass             = done && (err_q == '0) && !timeout_q;
        timeout          = timeout_q;
        err_count        = err_q;
        sample_count     = smp_q;
        coverage         = cov_q;
        first_fail_vec   = ffv_q;
        first_fail_mask  = ffm_q;
        first_fail_valid = ffval_q;
        state_dbg        = state_q;
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: four instances with different
// TIMEOUT/CNT_W share one stimulus stream and are checked with immediate asserts.
module tb_gate_response_checker;
    import gate_check_pkg::*;

    logic clk = 1'b0;
    logic rst, start, sample_valid, a, b;
    logic y_not, y_and, y_or, y_xor, y_nor, y_nand;

    int checks = 0;
    int errors = 0;

    // default instance (CNT_W=8, TIMEOUT=64)
    logic m_busy, m_done, m_pass, m_to, m_ffval;
    logic [7:0] m_err, m_smp;
    logic [3:0] m_cov;
    logic [1:0] m_ffv, m_state;
    logic [5:0] m_ffm;
    // TIMEOUT=8 instance
    logic t8_busy, t8_done, t8_pass, t8_to, t8_ffval;
    logic [7:0] t8_err, t8_smp;
    logic [3:0] t8_cov;
    logic [1:0] t8_ffv, t8_state;
    logic [5:0] t8_ffm;
    // TIMEOUT=4 instance
    logic t4_busy, t4_done, t4_pass, t4_to, t4_ffval;
    logic [7:0] t4_err, t4_smp;
    logic [3:0] t4_cov;
    logic [1:0] t4_ffv, t4_state;
    logic [5:0] t4_ffm;
    // CNT_W=2, TIMEOUT=16 instance for saturation
    logic s_busy, s_done, s_pass, s_to, s_ffval;
    logic [1:0] s_err, s_smp;
    logic [3:0] s_cov;
    logic [1:0] s_ffv, s_state;
    logic [5:0] s_ffm;

    gate_response_checker u_main (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid), .a(a), .b(b),
        .y_not(y_not), .y_and(y_and), .y_or(y_or), .y_xor(y_xor), .y_nor(y_nor), .y_nand(y_nand),
        .busy(m_busy), .done(m_done), .pass(m_pass), .timeout(m_to), .err_count(m_err),
        .sample_count(m_smp), .coverage(m_cov), .first_fail_vec(m_ffv), .first_fail_mask(m_ffm),
        .first_fail_valid(m_ffval), .state_dbg(m_state)
    );

    gate_response_checker #(.CNT_W(8), .TIMEOUT(8)) u_t8 (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid), .a(a), .b(b),
        .y_not(y_not), .y_and(y_and), .y_or(y_or), .y_xor(y_xor), .y_nor(y_nor), .y_nand(y_nand),
        .busy(t8_busy), .done(t8_done), .pass(t8_pass), .timeout(t8_to), .err_count(t8_err),
        .sample_count(t8_smp), .coverage(t8_cov), .first_fail_vec(t8_ffv), .first_fail_mask(t8_ffm),
        .first_fail_valid(t8_ffval), .state_dbg(t8_state)
    );

    gate_response_checker #(.CNT_W(8), .TIMEOUT(4)) u_t4 (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid), .a(a), .b(b),
        .y_not(y_not), .y_and(y_and), .y_or(y_or), .y_xor(y_xor), .y_nor(y_nor), .y_nand(y_nand),
        .busy(t4_busy), .done(t4_done), .pass(t4_pass), .timeout(t4_to), .err_count(t4_err),
        .sample_count(t4_smp), .coverage(t4_cov), .first_fail_vec(t4_ffv), .first_fail_mask(t4_ffm),
        .first_fail_valid(t4_ffval), .state_dbg(t4_state)
    );

    gate_response_checker #(.CNT_W(2), .TIMEOUT(16)) u_sat (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid), .a(a), .b(b),
        .y_not(y_not), .y_and(y_and), .y_or(y_or), .y_xor(y_xor), .y_nor(y_nor), .y_nand(y_nand),
        .busy(s_busy), .done(s_done), .pass(s_pass), .timeout(s_to), .err_count(s_err),
        .sample_count(s_smp), .coverage(s_cov), .first_fail_vec(s_ffv), .first_fail_mask(s_ffm),
        .first_fail_valid(s_ffval), .state_dbg(s_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one vector with correct gate outputs, optionally flipped by flip
    // ({not,and,or,xor,nor,nand}), then advance one clock.
    task automatic drive(input logic v, input logic ia, input logic ib, input logic [5:0] flip);
        sample_valid = v;
        a            = ia;
        b            = ib;
        y_not        = ~ia ^ flip[5];
        y_and        = (ia & ib) ^ flip[4];
        y_or         = (ia | ib) ^ flip[3];
        y_xor        = (ia ^ ib) ^ flip[2];
        y_nor        = ~(ia | ib) ^ flip[1];
        y_nand       = ~(ia & ib) ^ flip[0];
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 6'b0);
        start = 1'b0;
    endtask

    task automatic chk_main_zero(input string tag);
        chk({tag, "_busy"}, 32'(m_busy), 0);
        chk({tag, "_done"}, 32'(m_done), 0);
        chk({tag, "_pass"}, 32'(m_pass), 0);
        chk({tag, "_to"}, 32'(m_to), 0);
        chk({tag, "_err"}, 32'(m_err), 0);
        chk({tag, "_smp"}, 32'(m_smp), 0);
        chk({tag, "_cov"}, 32'(m_cov), 0);
        chk({tag, "_ffv"}, 32'(m_ffv), 0);
        chk({tag, "_ffm"}, 32'(m_ffm), 0);
        chk({tag, "_ffval"}, 32'(m_ffval), 0);
        chk({tag, "_state"}, 32'(m_state), 32'(ST_IDLE));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sample_valid = 1'b0; a = 1'b0; b = 1'b0;
        y_not = 1'b0; y_and = 1'b0; y_or = 1'b0; y_xor = 1'b0; y_nor = 1'b0; y_nand = 1'b0;

        // Reset with sample_valid toggling, then idle with valid samples ignored
        drive(1'b1, 1'b0, 1'b1, 6'b000001);
        drive(1'b0, 1'b1, 1'b0, 6'b0);
        chk_main_zero("reset");
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 6'b111111);
        drive(1'b1, 1'b0, 1'b0, 6'b0);
        chk_main_zero("idle");

        // Clean sweep; TIMEOUT=4 instance sees the last combination in its final cycle
        do_start();
        chk("sw_busy", 32'(m_busy), 1);
        drive(1'b1, 1'b0, 1'b0, 6'b0);
        drive(1'b1, 1'b0, 1'b1, 6'b0);
        drive(1'b1, 1'b1, 1'b0, 6'b0);
        chk("sw_mid_done", 32'(m_done), 0);
        chk("sw_mid_smp", 32'(m_smp), 3);
        chk("sw_mid_cov", 32'(m_cov), 32'h7);
        drive(1'b1, 1'b1, 1'b1, 6'b0);
        chk("sw_done", 32'(m_done), 1);
        chk("sw_busy_lo", 32'(m_busy), 0);
        chk("sw_pass", 32'(m_pass), 1);
        chk("sw_err", 32'(m_err), 0);
        chk("sw_smp", 32'(m_smp), 4);
        chk("sw_cov", 32'(m_cov), 32'hF);
        chk("sw_to", 32'(m_to), 0);
        chk("sw_ffval", 32'(m_ffval), 0);
        chk("col_done", 32'(t4_done), 1);
        chk("col_to", 32'(t4_to), 0);
        chk("col_pass", 32'(t4_pass), 1);
        chk("sat_smp_sweep", 32'(s_smp), 3);

        // Timeout: only 00 and 11, with y_not flipped; start mid-run is ignored
        do_start();
        for (int i = 0; i < 8; i++) begin
            start = (i == 2);
            drive(1'b1, (i % 2 == 1), (i % 2 == 1), 6'b100000);
            start = 1'b0;
            if (i == 6) chk("to8_not_yet", 32'(t8_done), 0);
        end
        chk("to8_done", 32'(t8_done), 1);
        chk("to8_to", 32'(t8_to), 1);
        chk("to8_cov", 32'(t8_cov), 32'b1001);
        chk("to8_pass", 32'(t8_pass), 0);
        chk("to8_smp", 32'(t8_smp), 8);
        chk("to8_err", 32'(t8_err), 8);
        chk("to8_ffv", 32'(t8_ffv), 0);
        chk("to8_ffm", 32'(t8_ffm), 32'b100000);
        chk("to4_to", 32'(t4_to), 1);
        chk("to4_smp_held", 32'(t4_smp), 4);
        chk("run_busy", 32'(m_busy), 1);
        chk("run_smp", 32'(m_smp), 8);
        chk("sat_smp", 32'(s_smp), 3);
        chk("sat_err", 32'(s_err), 3);

        // Complete coverage on the long-timeout instances
        drive(1'b1, 1'b0, 1'b1, 6'b0);
        drive(1'b1, 1'b1, 1'b0, 6'b0);
        chk("fin_done", 32'(m_done), 1);
        chk("fin_to", 32'(m_to), 0);
        chk("fin_err", 32'(m_err), 8);
        chk("fin_pass", 32'(m_pass), 0);
        chk("sat_done", 32'(s_done), 1);
        chk("sat_err_hold", 32'(s_err), 3);

        // Fault injection: y_xor stuck at 0
        do_start();
        chk("ft_clear_err", 32'(m_err), 0);
        drive(1'b1, 1'b0, 1'b0, 6'b0);
        drive(1'b1, 1'b0, 1'b1, 6'b000100);
        drive(1'b1, 1'b1, 1'b0, 6'b000100);
        drive(1'b1, 1'b1, 1'b1, 6'b0);
        chk("ft_done", 32'(m_done), 1);
        chk("ft_err", 32'(m_err), 2);
        chk("ft_ffv", 32'(m_ffv), 32'b01);
        chk("ft_ffm", 32'(m_ffm), 32'b000100);
        chk("ft_ffval", 32'(m_ffval), 1);
        chk("ft_pass", 32'(m_pass), 0);
        chk("ft_smp", 32'(m_smp), 4);
        drive(1'b1, 1'b1, 1'b1, 6'b111111);
        drive(1'b1, 1'b0, 1'b0, 6'b010000);
        chk("dn_hold_err", 32'(m_err), 2);
        chk("dn_hold_smp", 32'(m_smp), 4);
        chk("dn_hold_ffm", 32'(m_ffm), 32'b000100);
        chk("dn_done", 32'(m_done), 1);

        // Mid-run reset, then two start-initiated sweeps
        do_start();
        drive(1'b1, 1'b0, 1'b0, 6'b000010);
        drive(1'b1, 1'b0, 1'b1, 6'b0);
        chk("mr_smp", 32'(m_smp), 2);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 6'b0);
        rst = 1'b0;
        chk_main_zero("mr_reset");
        do_start();
        drive(1'b1, 1'b0, 1'b0, 6'b0);
        drive(1'b1, 1'b1, 1'b1, 6'b0);
        drive(1'b1, 1'b1, 1'b1, 6'b0);
        chk("rep_cov", 32'(m_cov), 32'b1001);
        drive(1'b1, 1'b0, 1'b1, 6'b0);
        drive(1'b1, 1'b1, 1'b0, 6'b0);
        chk("rep_done", 32'(m_done), 1);
        chk("rep_smp", 32'(m_smp), 5);
        do_start();
        chk("rs_busy", 32'(m_busy), 1);
        chk("rs_smp_clr", 32'(m_smp), 0);
        chk("rs_cov_clr", 32'(m_cov), 0);
        drive(1'b1, 1'b1, 1'b1, 6'b0);
        drive(1'b0, 1'b0, 1'b0, 6'b0);
        drive(1'b1, 1'b1, 1'b0, 6'b0);
        drive(1'b1, 1'b0, 1'b1, 6'b0);
        chk("rs_busy_gap", 32'(m_busy), 1);
        drive(1'b1, 1'b0, 1'b0, 6'b0);
        chk("rs_done", 32'(m_done), 1);
        chk("rs_smp", 32'(m_smp), 4);
        chk("rs_pass", 32'(m_pass), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
